// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch path.
package fetch_pkg;

    localparam int          DEFAULT_ADDR_W   = 32;
    localparam int          DEFAULT_INSTR_W  = 32;
    localparam int          DEFAULT_DEPTH    = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_STEP  = 4;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy must be able to represent DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [$clog2(DEFAULT_DEPTH):0] fetch_cnt_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch queue with flush; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  CW    = cnt_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  T              wdata_i,
    output logic [CW-1:0] count_o,
    output T              head_o
);

    localparam int PW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// PC generation, credit-based issue to 1-cycle imem, prefetch queue to decode.
// Optional FETCH_PERF_EN adds popped/flushed performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = DEFAULT_ADDR_W,
    parameter int                       INSTR_WIDTH   = DEFAULT_INSTR_W,
    parameter int                       DEPTH         = DEFAULT_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter int                       PC_STEP       = DEFAULT_PC_STEP
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [INSTR_WIDTH-1:0]   imem_rdata,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_flushed
`endif
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]   instr;
    } entry_t;

    localparam int CW = cnt_width(DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, tag_q;
    logic                     inflight_q;
    logic                     issue, push, pop;
    logic [CW-1:0]            count;
    logic [CW:0]              credit;
    entry_t                   head, wdata;

    // The pending response holds a slot, so a full queue plus in-flight never overflows.
    assign credit = {1'b0, count} + (CW+1)'(inflight_q);
    assign issue  = rst && !redirect_valid && (credit < (CW+1)'(DEPTH));
    assign push   = inflight_q && !redirect_valid;
    assign pop    = out_valid && out_ready && !redirect_valid;
    assign wdata  = '{pc: tag_q, instr: imem_rdata};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (issue)     pc_d = pc_q + ADDRESS_WIDTH'(PC_STEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) tag_q <= pc_q;
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wdata),
        .count_o (count),
        .head_o  (head)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign busy      = out_valid || inflight_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, flushed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (pop)            fetched_q <= fetched_q + 32'd1;
            if (redirect_valid) flushed_q <= flushed_q + 32'(credit);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .busy           (busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    // Instruction memory: word index of the address, one cycle after the request.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc, m_tag;
    int          m_infl;
    logic [31:0] m_fetched, m_flushed;

    int checks = 0;
    int errors = 0;
    int cyc, first_req, first_valid, nreq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_tag     = 32'h0;
        m_infl    = 0;
        m_fetched = 32'h0;
        m_flushed = 32'h0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_imem_req"},  imem_req,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_pc"},    out_pc,    0);
        chk({tag, "_out_instr"}, out_instr, 0);
        chk({tag, "_busy"},      busy,      0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 0);
        chk({tag, "_perf_flushed"}, perf_flushed, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b0;
        #1;
        check_cleared("reset");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    // One clock: drive, compare against the model, then advance the model by the rules.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic e_req, e_valid;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        e_req   = !rv && (m_q.size() + m_infl < D);
        e_valid = (m_q.size() != 0);
        chk("imem_req", imem_req, e_req);
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", out_valid, e_valid);
        if (e_valid) begin
            chk("out_pc",    out_pc,    m_q[0].pc);
            chk("out_instr", out_instr, m_q[0].instr);
        end
        chk("busy", busy, e_valid || (m_infl != 0));
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
        if (imem_req) nreq++;
        if (imem_req && first_req < 0)    first_req = cyc;
        if (out_valid && first_valid < 0) first_valid = cyc;
        cyc++;
        @(posedge clk);
        if (rv) begin
            m_flushed += 32'(m_q.size() + m_infl);
            m_q.delete();
            m_infl = 0;
            m_pc   = rpc;
        end else begin
            if (e_valid && rdy) begin
                void'(m_q.pop_front());
                m_fetched++;
            end
            if (m_infl != 0) m_q.push_back('{pc: m_tag, instr: m_tag >> 2});
            if (e_req) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            m_infl = e_req ? 1 : 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // Reset state and streaming with first-instruction latency.
        do_reset();
        cyc = 0; first_req = -1; first_valid = -1;
        repeat (8) cycle(1'b1, 1'b0, 32'h0);
        chk("first_req_cycle", first_req, 0);
        chk("first_valid_latency", first_valid - first_req, 2);

        // Backpressure: only DEPTH requests issue, head holds at pc 0.
        do_reset();
        nreq = 0;
        repeat (10) cycle(1'b0, 1'b0, 32'h0);
        chk("backpressure_req_count", nreq, D);
        chk("backpressure_head_pc", out_pc, 0);

        // Redirect with 3 queued and 1 in flight.
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("pre_redirect_depth", m_q.size() + m_infl, 4);
        cycle(1'b1, 1'b1, 32'h100);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects: last wins.
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b1, 32'h300);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // PC wrap past the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Randomized ready, redirects, misaligned targets.
        for (int i = 0; i < 400; i++) begin
            logic        r, v;
            logic [31:0] t;
            r = ($urandom_range(0, 9) < 7);
            v = ($urandom_range(0, 19) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            cycle(r, v, t);
        end

        // Asynchronous reset mid-stream: 2 queued, 1 in flight.
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        chk("pre_async_reset_depth", m_q.size() + m_infl, 3);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_cleared("async_reset");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the fixed counter-plus-ROM fetch path.
- Generates the PC and issues requests to a synchronous instruction memory with fixed 1-cycle read latency.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, presented to decode over a valid/ready handshake.
- Supports branch/jump redirect with queue flush and discard of the in-flight response; sits between instruction memory and the control/sign-extend/decode logic.

Parameters:
ADDRESS_WIDTH, 32, PC and memory address width
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
imem_req  output  1  read request this cycle
imem_addr  output  ADDRESS_WIDTH  request address, valid when imem_req=1
imem_rdata  input  INSTR_WIDTH  read data, valid exactly 1 cycle after imem_req
redirect_valid  input  1  redirect PC this cycle (branch/jump taken)
redirect_pc  input  ADDRESS_WIDTH  redirect target
out_valid  output  1  queue head is valid
out_ready  input  1  decode accepts head
out_instr  output  INSTR_WIDTH  head instruction
out_pc  output  ADDRESS_WIDTH  PC of head instruction
busy  output  1  queue non-empty or response in flight

Behaviour:
- Reset (rst=0, asynchronous): fetch PC = RESET_PC, queue empty, in-flight flag clear. Outputs: imem_req=0, out_valid=0, out_instr=0, out_pc=0, busy=0. Reset asserted mid-operation drops all entries and the in-flight response immediately.
- Issue rule: imem_req=1 when redirect_valid=0 and (count + inflight) < DEPTH. Credit counts the slot reserved for the pending response, so the queue never overflows.
- imem_addr = fetch PC. On issue, fetch PC <= fetch PC + PC_STEP (modulo 2^ADDRESS_WIDTH, wrap silently). inflight <= 1, tagged with the PC issued.
- Response: the cycle after an issue, {tagged PC, imem_rdata} is written at the tail unless discarded. Write and pop in the same cycle are both honoured; count unchanged.
- Output: out_valid = (count != 0), head entry driven combinationally from the queue. Pop on out_valid && out_ready. Head must be held stable while out_valid && !out_ready.
- Latency: first instruction after reset release appears on out_valid 2 cycles after the first imem_req (issue cycle, write cycle, visible next cycle). Throughput is 1 instr/cycle sustained when out_ready=1.
- Redirect (redirect_valid=1):
  - Queue flushed; count <= 0.
  - fetch PC <= redirect_pc; no issue this cycle.
  - Any response arriving next cycle is discarded.
  - Any pop in the same cycle is ignored; out_valid drops to 0 the following cycle.
  - First fetch of redirect_pc is issued the next cycle.
- Back-to-back redirects: the last one wins; each one flushes.
- Full: count = DEPTH, so no issue, and fetch PC holds.
- Empty with out_ready=1: no pop, no underflow.
- Misaligned redirect_pc (low 2 bits != 0) is passed through unchanged; checking it is not this block's responsibility.

Optional Feature:
FETCH_PERF_EN defined:
- Adds outputs perf_fetched[31:0] (incremented per instruction popped) and perf_flushed[31:0] (incremented by the number of entries discarded per redirect, including a discarded in-flight response).
- Both counters reset to 0 and wrap.
FETCH_PERF_EN undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - typedef fetch_entry_t (packed struct {pc, instr})
  - constants DEFAULT_RESET_PC and DEFAULT_PC_STEP
  - typedef for the count width, $clog2(DEPTH)+1
- One sub-module, fetch_fifo: synchronous DEPTH-entry queue of fetch_entry_t with push, pop, flush, count, and head output; async active-low reset.
- fetch_unit contains the PC register, credit/issue logic, in-flight tag, and the fetch_fifo instance.

Test Plan:
- Reset then out_ready=1, memory returns addr/4 as data: out_pc sequence 0,4,8,12 with out_instr 0,1,2,3. First out_valid 2 cycles after the first imem_req, then 1/cycle.
- out_ready=0 for 10 cycles (DEPTH=4): exactly 4 requests issued (addrs 0,4,8,12), then imem_req=0. count stays 4 and the head (pc 0) holds stable.
- Redirect to 0x100 while the queue holds 3 entries and one is in flight: out_valid=0 next cycle. The next imem_addr is 0x100 and the next out_pc is 0x100; old entries are never seen.
- Redirect on two consecutive cycles (0x200 then 0x300): only 0x300 onward is fetched; nothing from 0x200 is delivered.
- PC wrap with RESET_PC=0xFFFFFFF8: out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- rst pulsed low mid-stream (queue 2 entries, 1 in flight): outputs clear asynchronously, before the next edge. After release, fetch restarts at RESET_PC. With FETCH_PERF_EN defined, perf counters read 0.
